bcd_display_ctrl: RTL and testbench
===================================

BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 Parameter N, default 14: width of the binary input, in bits; legal range 4..14.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per display digit slot; must be at least 2.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous assertion, active-low.
REQ-005 start  input  1  Conversion request; sampled only in IDLE.
REQ-006 binary  input  N  Unsigned value; captured in the cycle start is accepted.
REQ-007 busy  output  1  High while a conversion is in progress.
REQ-008 done  output  1  One-cycle pulse when the result registers update.
REQ-009 ovf  output  1  Registered flag; set when the last accepted value exceeded 9999.
REQ-010 thousands, hundreds, tens, ones  output  4 each  Registered BCD result.
REQ-011 an  output  4  Digit enables, active-low; an[0] drives the ones digit.
REQ-012 seg  output  7  Segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL:
- capture binary into a shift register;
- clear the four working BCD nibbles and the iteration counter;
- go to SHIFT.
REQ-015 SHIFT SHALL perform exactly one double-dabble step per cycle:
- add 3 to each working nibble that is >= 5;
- shift the concatenation {nibbles, shift register} left by 1.
REQ-016 After N SHIFT cycles the FSM SHALL go to DONE; DONE SHALL return to IDLE unconditionally after one cycle.
REQ-017 Timing, with the start-accept edge as cycle 0:
- busy = 1 during cycles 1..N+1;
- done = 1 in cycle N+1 only;
- the result outputs and ovf change only on that same edge.
REQ-018 In DONE, if the converted value exceeds 9999, the block SHALL set ovf=1 and load 9,9,9,9 into the result outputs; otherwise it SHALL clear ovf and load the computed digits.
REQ-019 start while busy=1 SHALL be ignored and SHALL NOT be queued; start in DONE is also ignored.
REQ-020 start held high SHALL begin a new conversion on the first IDLE cycle after DONE.
REQ-021 Display scan:
- a free-running prescaler counts 0..REFRESH_DIV-1;
- a 2-bit digit index increments, wrapping 3->0, on each prescaler terminal count;
- the scan runs independently of the conversion FSM.
REQ-022 Exactly one an bit SHALL be low at any time, selected by the digit index.
REQ-023 Leading-zero blanking: thousands, hundreds and tens SHALL show seg=7'h7F while they and every higher digit are 0; ones SHALL never be blanked.
REQ-024 seg SHALL be the registered decode of the selected result digit, valid one cycle after an changes.
REQ-025 The decoder SHALL output 7'h7F for nibble values 10..15.

Reset
REQ-026 While rst_n=0:
- the FSM SHALL be in IDLE;
- busy, done and ovf SHALL be 0;
- all digits, the prescaler and the digit index SHALL be 0;
- an SHALL be 4'b1110;
- seg SHALL be 7'b1000000 (a "0").
REQ-027 Reset asserted mid-conversion SHALL abandon the conversion without producing a done pulse.
REQ-028 Deassertion of rst_n SHALL be synchronous; the first start can be accepted on the second rising edge after release.

Structure
REQ-029 A shared package bcd_pkg SHALL hold:
- the state enum {IDLE, SHIFT, DONE};
- the segment constants SEG_BLANK = 7'h7F and SEG_DIGIT[0..9];
- the constant BCD_MAX = 9999.
REQ-030 The 4-bit-to-segment decoder SHALL be the single sub-module bcd_seg7_decode, purely combinational; the output register lives in the parent.

Verification
REQ-031 Verification SHALL use N=14 and REFRESH_DIV=4. binary=1234 with a 1-cycle start -> busy for 15 cycles, done at cycle 15, digits 1,2,3,4, ovf=0.
REQ-032 binary=9999 -> digits 9,9,9,9, ovf=0; then binary=10000 -> ovf=1, digits 9,9,9,9.
REQ-033 binary=0 -> digits 0,0,0,0; over one scan cycle only the an=1110 slot shows 7'b1000000, the other three show 7'h7F.
REQ-034 binary=42, then start re-asserted with binary=7 at cycle 5 -> second start ignored, result 0,0,4,2, exactly one done pulse.
REQ-035 rst_n pulsed low at cycle 7 of a conversion of 500 -> no done, digits stay 0; a new start afterwards converts correctly.
REQ-036 Scan check -> an steps 1110, 1101, 1011, 0111, then repeats, advancing every 4 clk cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD display controller:
//   - state_e   : conversion FSM states
//   - SEG_BLANK : all segments off (active-low)
//   - SEG_DIGIT : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   - BCD_MAX   : largest value representable on four BCD digits
//   - dd_adjust : the per-nibble "add 3 if >= 5" double-dabble correction
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam int unsigned BCD_MAX = 9999;

    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// -----------------------------------------------------------------------------
// bcd_seg7_decode
// Purely combinational 4-bit to 7-segment decoder, active-low outputs.
// Non-decimal nibbles (10..15) produce a blank pattern.
//   nib_i : nibble to decode
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_seg7_decode
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (nib_i < 4'd10) begin
            seg_o = SEG_DIGIT[nib_i];
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_display_ctrl
// Converts an N-bit unsigned value to four BCD digits with a sequential
// double-dabble (one shift per clock) and drives a multiplexed 4-digit
// common-anode style display with leading-zero blanking.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : reset, asynchronous assert / synchronous release, active-low
//   start      : conversion request, only honoured in IDLE
//   binary     : value to convert, captured when start is accepted
//   busy       : conversion in progress (cycles 1..N+1 after the accept edge)
//   done       : one-cycle pulse coincident with the result update
//   ovf        : last accepted value exceeded 9999 (result shows 9999)
//   thousands, hundreds, tens, ones : registered BCD result
//   an         : digit enables, active-low, an[0] = ones
//   seg        : registered segment pattern {g,f,e,d,c,b,a}, active-low
//
// Handshake: start is a level request; it is sampled on every rising edge
// while the FSM is in IDLE and is ignored (not queued) in SHIFT and DONE.
// -----------------------------------------------------------------------------
module bcd_display_ctrl
    import bcd_pkg::*;
#(
    parameter int N           = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] binary,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [3:0]   thousands,
    output logic [3:0]   hundreds,
    output logic [3:0]   tens,
    output logic [3:0]   ones,
    output logic [3:0]   an,
    output logic [6:0]   seg
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [15:0] ALL_NINES = 16'h9999;

    // Reset release is retimed by a single flop so that every other flop
    // leaves reset on the same edge; assertion stays asynchronous.
    logic rst_sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 1'b0;
        else        rst_sync_q <= 1'b1;
    end

    // ---------------- conversion FSM ----------------
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   sr_q;
    logic [15:0]    work_q;
    logic           ovf_pend_q;
    logic [15:0]    result_q;
    logic           ovf_q, busy_q, done_q;
    logic           accept, step, load, busy_d;
    logic [15:0]    adj;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(N - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        load   = 1'b0;
        busy_d = 1'b0;
        unique case (state_q)
            IDLE:    accept = start;
            SHIFT:   begin step = 1'b1; busy_d = 1'b1; end
            DONE:    begin load = 1'b1; busy_d = 1'b1; end
            default: ;
        endcase
    end

    assign adj = {dd_adjust(work_q[15:12]), dd_adjust(work_q[11:8]),
                  dd_adjust(work_q[7:4]),   dd_adjust(work_q[3:0])};

    // busy/done are registered from the state, so they lag it by one cycle:
    // the DONE state is what produces the done pulse and the result load.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            work_q     <= '0;
            ovf_pend_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= load;
            if (accept) begin
                sr_q       <= binary;
                work_q     <= '0;
                cnt_q      <= '0;
                ovf_pend_q <= (32'(binary) > BCD_MAX);
            end else if (step) begin
                // Bit shifted out of the thousands nibble is dropped; values
                // above 9999 are caught by ovf_pend_q instead.
                {work_q, sr_q} <= {adj[14:0], sr_q, 1'b0};
                cnt_q          <= cnt_q + CW'(1);
            end
            if (load) begin
                ovf_q    <= ovf_pend_q;
                result_q <= ovf_pend_q ? ALL_NINES : work_q;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign thousands = result_q[15:12];
    assign hundreds  = result_q[11:8];
    assign tens      = result_q[7:4];
    assign ones      = result_q[3:0];

    // ---------------- display scan ----------------
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic          tc;
    logic [3:0]    sel_nib;
    logic          blank;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_q;

    assign tc = (presc_q == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            presc_q <= tc ? '0 : presc_q + PW'(1);
            if (tc) idx_q <= idx_q + 2'd1;
        end
    end

    // A digit is blanked while it and every more significant digit are zero.
    always_comb begin
        sel_nib = result_q[3:0];
        blank   = 1'b0;
        unique case (idx_q)
            2'd0: begin sel_nib = result_q[3:0];   blank = 1'b0;                     end
            2'd1: begin sel_nib = result_q[7:4];   blank = (result_q[15:4]  == '0);  end
            2'd2: begin sel_nib = result_q[11:8];  blank = (result_q[15:8]  == '0);  end
            2'd3: begin sel_nib = result_q[15:12]; blank = (result_q[15:12] == '0);  end
            default: ;
        endcase
    end

    bcd_seg7_decode u_dec (
        .nib_i (sel_nib),
        .seg_o (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) seg_q <= SEG_DIGIT[0];
        else             seg_q <= blank ? SEG_BLANK : dec_seg;
    end

    assign an  = ~(4'b0001 << idx_q);
    assign seg = seg_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_ctrl
// Directed bench for bcd_display_ctrl with N=14, REFRESH_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge. Period k
// means the interval after the k-th rising edge counted from the start-accept
// edge (k = 0).
// -----------------------------------------------------------------------------
module tb_bcd_display_ctrl;

    localparam int N  = 14;
    localparam int RD = 4;

    // Hand-written active-low {g,f,e,d,c,b,a} patterns, blank above 9.
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] binary;
    logic         busy, done, ovf;
    logic [3:0]   thousands, hundreds, tens, ones, an;
    logic [6:0]   seg;

    always #5 clk = ~clk;

    bcd_display_ctrl #(.N(N), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .binary    (binary),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .an        (an),
        .seg       (seg)
    );

    // ---------------- checking ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: {ovf, thousands, hundreds, tens, ones} expected per done.
    logic [16:0] exp_q[$];
    logic [16:0] exp_e;

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check_eq("done_unexpected", 32'(done), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check_eq("result", 32'({ovf, thousands, hundreds, tens, ones}), 32'(exp_e));
            end
        end
    end

    function automatic logic [6:0] exp_seg(input logic [15:0] dig, input logic [3:0] an_v);
        int          pos;
        logic [15:0] hi;
        pos = 0;
        for (int p = 0; p < 4; p++) if (!an_v[p]) pos = p;
        hi = dig >> (4 * pos);
        if (pos > 0 && hi == 16'h0) return 7'h7F;
        return SEG_TBL[hi[3:0]];
    endfunction

    // ---------------- driver tasks ----------------
    int bc, fd, nd;

    // Step `cycles` periods; optionally raise start for one period at glitch_k.
    task automatic watch(input int cycles, input int glitch_k, input logic [N-1:0] glitch_val,
                         output int busy_cnt, output int first_done, output int n_done);
        busy_cnt   = 0;
        first_done = -1;
        n_done     = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            start = (k == glitch_k);
            if (k == glitch_k) binary = glitch_val;
        end
    endtask

    task automatic convert(input logic [N-1:0] val, input logic [16:0] exp,
                           input int glitch_k, input logic [N-1:0] glitch_val);
        @(negedge clk);
        binary = val;
        start  = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_p0", 32'(busy), 32'd0);
        watch(N + 6, glitch_k, glitch_val, bc, fd, nd);
        check_eq("busy_len", 32'(bc), 32'(N + 1));
        check_eq("done_at", 32'(fd), 32'(N + 1));
        check_eq("done_cnt", 32'(nd), 32'd1);
        check_eq("ovf", 32'(ovf), 32'(exp[16]));
        check_eq("digits", 32'({thousands, hundreds, tens, ones}), 32'(exp[15:0]));
    endtask

    task automatic scan(input logic [15:0] dig, input int cycles);
        logic [3:0] prev_an;
        int         since;
        int         changes;
        @(negedge clk);
        prev_an = an;
        since   = 0;
        changes = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check_eq("an_onehot", 32'($countones(~an)), 32'd1);
            if (an != prev_an) begin
                check_eq("an_step", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
                if (changes > 0) check_eq("an_period", 32'(since), 32'(RD));
                changes++;
                since = 1;
            end else begin
                since++;
                check_eq("seg", 32'(seg), 32'(exp_seg(dig, an)));
            end
            prev_an = an;
        end
        check_eq("an_changes", 32'(changes >= 4), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    int first_d, second_d, n_d;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        binary = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_digits", 32'({thousands, hundreds, tens, ones}), 32'd0);
        check_eq("rst_an", 32'(an), 32'h0E);
        check_eq("rst_seg", 32'(seg), 32'h40);

        // Release reset with start already high: accept must be on edge 2.
        binary = 14'd1234;
        start  = 1'b1;
        rst_n  = 1'b1;
        exp_q.push_back(17'h01234);
        @(negedge clk);
        check_eq("rel_e1_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("rel_e2_busy", 32'(busy), 32'd0);
        watch(N + 6, 0, '0, bc, fd, nd);
        check_eq("c1234_busy_len", 32'(bc), 32'(N + 1));
        check_eq("c1234_done_at", 32'(fd), 32'(N + 1));
        check_eq("c1234_digits", 32'({ovf, thousands, hundreds, tens, ones}), 32'h01234);
        scan(16'h1234, 24);

        convert(14'd9999,  17'h09999, 0, '0);
        convert(14'd10000, 17'h19999, 0, '0);
        convert(14'd16383, 17'h19999, 0, '0);
        convert(14'd0,     17'h00000, 0, '0);
        scan(16'h0000, 20);
        convert(14'd42,    17'h00042, 5, 14'd7);
        check_eq("glitch_idle", 32'(busy), 32'd0);
        scan(16'h0042, 20);
        convert(14'd100,   17'h00100, 0, '0);
        scan(16'h0100, 20);

        // start held high across DONE restarts on the first IDLE cycle.
        @(negedge clk);
        binary = 14'd1234;
        start  = 1'b1;
        exp_q.push_back(17'h01234);
        exp_q.push_back(17'h01234);
        first_d  = -1;
        second_d = -1;
        n_d      = 0;
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            if (k == 16) start = 1'b0;
            if (done) begin
                n_d++;
                if (first_d < 0) first_d = k;
                else             second_d = k;
            end
        end
        check_eq("held_done_cnt", 32'(n_d), 32'd2);
        check_eq("held_first", 32'(first_d), 32'(N + 1));
        check_eq("held_second", 32'(second_d), 32'(2 * N + 3));

        // Reset during a conversion of 500 abandons it.
        @(negedge clk);
        binary = 14'd500;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_an", 32'(an), 32'h0E);
        rst_n = 1'b1;
        watch(N + 6, 0, '0, bc, fd, nd);
        check_eq("midrst_no_done", 32'(nd), 32'd0);
        check_eq("midrst_no_busy", 32'(bc), 32'd0);
        check_eq("midrst_digits", 32'({ovf, thousands, hundreds, tens, ones}), 32'd0);
        convert(14'd500, 17'h00500, 0, '0);

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
